// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap sequencer for the RV32I pipeline.
// Services CSRRW, samples timer/external interrupts and issues one-cycle PC redirects.
module csr_unit #(
  parameter bit MCYCLE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_rd,
  input  logic        csr_wr,
  input  logic        is_mret,
  input  logic [31:0] inst,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        irq_ok,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] rdata,
  output logic        epc_taken,
  output logic [31:0] epc_pc
);
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

  typedef enum logic {S_IDLE = 1'b0, S_REDIRECT = 1'b1} state_t;

  state_t      r_state;
  logic        r_mie, r_mpie, r_mtie, r_meie, r_mtip, r_meip;
  logic [31:0] r_mtvec, r_mepc, r_mcause, r_epc_pc;
  logic [63:0] r_mcycle;
  logic        r_epc_taken;

  logic [11:0] w_addr;
  logic        w_pend_e, w_pend_t, w_take, w_mret;
  logic [3:0]  w_cause;
  logic [31:0] w_trap_pc, w_csr_val;
  logic        w_unused;

  assign w_addr    = inst[31:20];
  assign w_unused  = ^inst[19:0];
  assign w_pend_e  = r_meip & r_meie;
  assign w_pend_t  = r_mtip & r_mtie;
  assign w_cause   = w_pend_e ? 4'd11 : 4'd7;
  assign w_mret    = (r_state == S_IDLE) && is_mret;
  // A CSR write defers the take so the interrupt sees the freshly written mie/mstatus.
  assign w_take    = (r_state == S_IDLE) && irq_ok && r_mie && (w_pend_e || w_pend_t)
                     && !csr_wr && !is_mret;
  assign w_trap_pc = {r_mtvec[31:2], 2'b00}
                     + (r_mtvec[0] ? {26'd0, w_cause, 2'b00} : 32'd0);

  // CSR read multiplexer.
  always_comb begin
    w_csr_val = 32'd0;
    case (w_addr)
      ADDR_MSTATUS: w_csr_val = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
      ADDR_MIE:     w_csr_val = {20'd0, r_meie, 3'd0, r_mtie, 7'd0};
      ADDR_MTVEC:   w_csr_val = r_mtvec;
      ADDR_MEPC:    w_csr_val = r_mepc;
      ADDR_MCAUSE:  w_csr_val = r_mcause;
      ADDR_MIP:     w_csr_val = {20'd0, r_meip, 3'd0, r_mtip, 7'd0};
      ADDR_MCYCLE:  w_csr_val = r_mcycle[31:0];
      ADDR_MCYCLEH: w_csr_val = r_mcycle[63:32];
      default:      w_csr_val = 32'd0;
    endcase
  end

  assign rdata     = (csr_rd && rst_n) ? w_csr_val : 32'd0;
  assign epc_taken = r_epc_taken;
  assign epc_pc    = r_epc_pc;

  // Interrupt pending flops sampling the level-sensitive sources.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mtip <= 1'b0;
      r_meip <= 1'b0;
    end else begin
      r_mtip <= timer_irq;
      r_meip <= ext_irq;
    end
  end

  // Free-running cycle counter; a write to either half replaces the increment.
  always_ff @(posedge clk) begin
    if (!rst_n || !MCYCLE_EN) begin
      r_mcycle <= 64'd0;
    end else if (csr_wr && (w_addr == ADDR_MCYCLE)) begin
      r_mcycle[31:0] <= wdata;
    end else if (csr_wr && (w_addr == ADDR_MCYCLEH)) begin
      r_mcycle[63:32] <= wdata;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  // Trap sequencer and the CSRs it shares with software writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mie       <= 1'b0;
      r_mpie      <= 1'b0;
      r_mtie      <= 1'b0;
      r_meie      <= 1'b0;
      r_mtvec     <= 32'd0;
      r_mepc      <= 32'd0;
      r_mcause    <= 32'd0;
      r_epc_taken <= 1'b0;
      r_epc_pc    <= 32'd0;
    end else begin
      if (csr_wr) begin
        case (w_addr)
          ADDR_MSTATUS: begin
            r_mie  <= wdata[3];
            r_mpie <= wdata[7];
          end
          ADDR_MIE: begin
            r_mtie <= wdata[7];
            r_meie <= wdata[11];
          end
          ADDR_MTVEC:  r_mtvec  <= {wdata[31:2], 1'b0, wdata[0]};
          ADDR_MEPC:   r_mepc   <= {wdata[31:2], 2'b00};
          ADDR_MCAUSE: r_mcause <= wdata;
          default: ;
        endcase
      end
      case (r_state)
        S_IDLE: begin
          if (w_mret) begin
            r_mie       <= r_mpie;
            r_mpie      <= 1'b1;
            r_epc_taken <= 1'b1;
            r_epc_pc    <= r_mepc;
            r_state     <= S_REDIRECT;
          end else if (w_take) begin
            r_mepc      <= pc;
            r_mcause    <= {1'b1, 27'd0, w_cause};
            r_mpie      <= r_mie;
            r_mie       <= 1'b0;
            r_epc_taken <= 1'b1;
            r_epc_pc    <= w_trap_pc;
            r_state     <= S_REDIRECT;
          end else begin
            r_epc_taken <= 1'b0;
          end
        end
        S_REDIRECT: begin
          r_epc_taken <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_epc_taken <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: CSRRW, traps, mret, mcycle and reset.
module tb_csr_unit;
  logic        clk = 1'b0;
  logic        rst_n, csr_rd, csr_wr, is_mret, irq_ok, timer_irq, ext_irq;
  logic [31:0] inst, wdata, pc, rdata, epc_pc;
  logic        epc_taken;
  int          checks = 0;
  int          errors = 0;

  csr_unit #(.MCYCLE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .csr_rd(csr_rd), .csr_wr(csr_wr), .is_mret(is_mret),
    .inst(inst), .wdata(wdata), .pc(pc), .irq_ok(irq_ok), .timer_irq(timer_irq),
    .ext_irq(ext_irq), .rdata(rdata), .epc_taken(epc_taken), .epc_pc(epc_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [11:0] addr, input logic [31:0] exp, input string tag);
    inst   = {addr, 20'd0};
    csr_rd = 1'b1;
    @(negedge clk);
    check(tag, rdata, exp);
    step();
    csr_rd = 1'b0;
  endtask

  task automatic csrrw(input logic [11:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_old, input string tag);
    inst   = {addr, 20'd0};
    wdata  = data;
    csr_rd = 1'b1;
    csr_wr = 1'b1;
    @(negedge clk);
    check(tag, rdata, exp_old);
    step();
    csr_rd = 1'b0;
    csr_wr = 1'b0;
  endtask

  task automatic wr_only(input logic [11:0] addr, input logic [31:0] data);
    inst   = {addr, 20'd0};
    wdata  = data;
    csr_wr = 1'b1;
    step();
    csr_wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; csr_rd = 1'b0; csr_wr = 1'b0; is_mret = 1'b0; irq_ok = 1'b0;
    timer_irq = 1'b0; ext_irq = 1'b0; inst = 32'd0; wdata = 32'd0; pc = 32'd0;

    // Reset
    inst = {12'h300, 20'd0};
    csr_rd = 1'b1;
    @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    csr_rd = 1'b0;
    step();
    step();
    check("rst_epc_taken", {31'd0, epc_taken}, 32'h0);
    check("rst_epc_pc", epc_pc, 32'h0);
    rst_n = 1'b1;

    // mtvec masking and swap semantics
    csrrw(12'h305, 32'h0000_1003, 32'h0, "mtvec_swap_old");
    rd_chk(12'h305, 32'h0000_1001, "mtvec_masked");

    // Timer trap, direct mode
    csrrw(12'h305, 32'h0000_0100, 32'h0000_1001, "mtvec_old2");
    csrrw(12'h304, 32'h0000_0080, 32'h0, "mie_old");
    csrrw(12'h300, 32'h0000_0008, 32'h0, "mstatus_old");
    irq_ok = 1'b1; pc = 32'h40; timer_irq = 1'b1;
    step();
    check("t_lat1_taken", {31'd0, epc_taken}, 32'h0);
    step();
    check("t_taken", {31'd0, epc_taken}, 32'h1);
    check("t_epc_pc", epc_pc, 32'h100);
    irq_ok = 1'b0; timer_irq = 1'b0;
    step();
    check("t_pulse_end", {31'd0, epc_taken}, 32'h0);
    rd_chk(12'h341, 32'h40, "t_mepc");
    rd_chk(12'h342, 32'h8000_0007, "t_mcause");
    rd_chk(12'h300, 32'h80, "t_mstatus");

    // External over timer, vectored mode
    csrrw(12'h305, 32'h0000_0101, 32'h100, "v_mtvec_old");
    csrrw(12'h304, 32'h0000_0880, 32'h80, "v_mie_old");
    csrrw(12'h300, 32'h0000_0008, 32'h80, "v_mstatus_old");
    irq_ok = 1'b1; pc = 32'h40; timer_irq = 1'b1; ext_irq = 1'b1;
    step();
    check("v_lat1_taken", {31'd0, epc_taken}, 32'h0);
    step();
    check("v_taken", {31'd0, epc_taken}, 32'h1);
    check("v_epc_pc", epc_pc, 32'h12C);
    irq_ok = 1'b0;
    step();
    check("v_pulse_end", {31'd0, epc_taken}, 32'h0);
    rd_chk(12'h342, 32'h8000_000B, "v_mcause");
    rd_chk(12'h300, 32'h80, "v_mstatus");
    rd_chk(12'h341, 32'h40, "v_mepc");

    // mret
    is_mret = 1'b1;
    step();
    check("mret_taken", {31'd0, epc_taken}, 32'h1);
    check("mret_epc_pc", epc_pc, 32'h40);
    is_mret = 1'b0;
    rd_chk(12'h300, 32'h88, "mret_mstatus");
    check("mret_pulse_end", {31'd0, epc_taken}, 32'h0);

    // mret with a pending interrupt: mret first, trap after REDIRECT
    pc = 32'h88; irq_ok = 1'b1; is_mret = 1'b1;
    step();
    check("mw_taken", {31'd0, epc_taken}, 32'h1);
    check("mw_epc_pc", epc_pc, 32'h40);
    is_mret = 1'b0;
    step();
    check("mw_redirect_gap", {31'd0, epc_taken}, 32'h0);
    step();
    check("mw_retrap_taken", {31'd0, epc_taken}, 32'h1);
    check("mw_retrap_pc", epc_pc, 32'h12C);
    irq_ok = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0;
    step();
    check("mw_pulse_end", {31'd0, epc_taken}, 32'h0);
    rd_chk(12'h341, 32'h88, "mw_mepc");
    rd_chk(12'h342, 32'h8000_000B, "mw_mcause");
    rd_chk(12'h300, 32'h80, "mw_mstatus");

    // Writes to mip and unimplemented addresses are ignored
    csrrw(12'h344, 32'hFFFF_FFFF, 32'h0, "mip_old");
    rd_chk(12'h344, 32'h0, "mip_ro");
    csrrw(12'h7C0, 32'hFFFF_FFFF, 32'h0, "unimpl_old");
    rd_chk(12'h7C0, 32'h0, "unimpl_ro");

    // mcycle carry into mcycleh
    wr_only(12'hB00, 32'hFFFF_FFFF);
    wr_only(12'hB80, 32'h0);
    rd_chk(12'hB80, 32'h0, "mcycleh_pre");
    rd_chk(12'hB00, 32'h0, "mcycle_wrap");
    rd_chk(12'hB80, 32'h1, "mcycleh_carry");

    // Reset during REDIRECT
    is_mret = 1'b1;
    step();
    check("rr_taken", {31'd0, epc_taken}, 32'h1);
    check("rr_epc_pc", epc_pc, 32'h88);
    is_mret = 1'b0;
    rst_n = 1'b0;
    step();
    check("rr_taken_dropped", {31'd0, epc_taken}, 32'h0);
    check("rr_epc_pc_zero", epc_pc, 32'h0);
    rd_chk(12'h300, 32'h0, "rr_mstatus");
    rd_chk(12'h304, 32'h0, "rr_mie");
    rd_chk(12'h305, 32'h0, "rr_mtvec");
    rd_chk(12'h341, 32'h0, "rr_mepc");
    rd_chk(12'h342, 32'h0, "rr_mcause");
    rd_chk(12'hB80, 32'h0, "rr_mcycleh");
    rst_n = 1'b1;
    rd_chk(12'h305, 32'h0, "post_rst_mtvec");
    check("post_rst_taken", {31'd0, epc_taken}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
